// File: rtl/fgs_pkg.sv
// Shared constants, FSM state type and packed-bus slice helpers for the
// calcfgs sum engine and its match-select consumer.
package fgs_pkg;

  localparam int N_CAND  = 16;
  localparam int IDX_W   = 4;
  localparam int FSUM_W  = 11;
  localparam int F2_W    = 14;
  localparam int G2_W    = 56;
  localparam int GS_W    = 44;
  localparam int FG_W    = 56;
  localparam int SCORE_W = 58;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Low bit of candidate k inside each packed per-candidate bus
  function automatic int g2_base(input logic [IDX_W-1:0] k);
    return int'(k) * G2_W;
  endfunction

  function automatic int gs_base(input logic [IDX_W-1:0] k);
    return int'(k) * GS_W;
  endfunction

  function automatic int fg_base(input logic [IDX_W-1:0] k);
    return int'(k) * FG_W;
  endfunction

endpackage

// File: rtl/fgs_ssd_score.sv
// Combinational SSD score for one candidate: f2sum + g2sum_k - 2*fg_k,
// evaluated in signed SCORE_W+1 bits and clamped at zero.
module fgs_ssd_score
  import fgs_pkg::*;
(
  input  logic [F2_W-1:0]    f2sum,
  input  logic [G2_W-1:0]    g2sum_k,
  input  logic [FG_W-1:0]    fg_k,
  output logic [SCORE_W-1:0] score
);

  localparam int RAW_W = SCORE_W + 1;

  logic signed [RAW_W-1:0] f2_ext;
  logic signed [RAW_W-1:0] g2_ext;
  logic signed [RAW_W-1:0] fg2_ext;
  logic signed [RAW_W-1:0] raw;

  // fg_k is doubled by appending a zero bit; all operands are non-negative
  assign f2_ext  = $signed({{(RAW_W-F2_W){1'b0}}, f2sum});
  assign g2_ext  = $signed({{(RAW_W-G2_W){1'b0}}, g2sum_k});
  assign fg2_ext = $signed({{(RAW_W-FG_W-1){1'b0}}, fg_k, 1'b0});
  assign raw     = f2_ext + g2_ext - fg2_ext;

  assign score = raw[RAW_W-1] ? '0 : raw[SCORE_W-1:0];

endmodule

// File: rtl/fgs_match_select.sv
// Snapshots the calcfgs per-candidate sums on frame complete, scans all
// candidates one per cycle and reports the best/runner-up SSD match.
module fgs_match_select
  import fgs_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FSUM_W-1:0]        fsum,
  input  logic [F2_W-1:0]          f2sum,
  input  logic [N_CAND*G2_W-1:0]   g2sum,
  input  logic [N_CAND*GS_W-1:0]   gsum,
  input  logic [N_CAND*FG_W-1:0]   fg,
  input  logic                     valid,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         best_idx,
  output logic [SCORE_W-1:0]       best_score,
  output logic [SCORE_W-1:0]       second_score,
  output logic                     is_unique,
  output logic [GS_W-1:0]          gsum_best,
  output logic [FSUM_W-1:0]        fsum_q,
  output logic                     overrun
);

  state_t state, state_next;

  logic                   valid_q;
  logic                   start;
  logic [IDX_W-1:0]       k;

  logic [FSUM_W-1:0]      snap_fsum;
  logic [F2_W-1:0]        snap_f2;
  logic [N_CAND*G2_W-1:0] snap_g2;
  logic [N_CAND*GS_W-1:0] snap_gs;
  logic [N_CAND*FG_W-1:0] snap_fg;

  logic [SCORE_W-1:0]     score;
  logic [SCORE_W-1:0]     run_best;
  logic [SCORE_W-1:0]     run_second;
  logic [IDX_W-1:0]       run_idx;

  assign start = valid & ~valid_q;
  assign busy  = (state != IDLE);

  fgs_ssd_score u_score (
    .f2sum   (snap_f2),
    .g2sum_k (snap_g2[g2_base(k) +: G2_W]),
    .fg_k    (snap_fg[fg_base(k) +: FG_W]),
    .score   (score)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (k == IDX_W'(N_CAND-1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // valid_q resets high so the producer's power-up valid level is not a start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b1;
      done         <= 1'b0;
      k            <= '0;
      snap_fsum    <= '0;
      snap_f2      <= '0;
      snap_g2      <= '0;
      snap_gs      <= '0;
      snap_fg      <= '0;
      run_best     <= '0;
      run_second   <= '0;
      run_idx      <= '0;
      best_idx     <= '0;
      best_score   <= '0;
      second_score <= '0;
      is_unique    <= 1'b0;
      gsum_best    <= '0;
      fsum_q       <= '0;
      overrun      <= 1'b0;
    end else begin
      valid_q <= valid;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_fsum  <= fsum;
            snap_f2    <= f2sum;
            snap_g2    <= g2sum;
            snap_gs    <= gsum;
            snap_fg    <= fg;
            k          <= '0;
            run_best   <= '1;
            run_second <= '1;
            run_idx    <= '0;
            overrun    <= 1'b0;
          end
        end
        SCAN: begin
          if (start) overrun <= 1'b1;
          // Strict compares so equal scores keep the lower index
          if (score < run_best) begin
            run_second <= run_best;
            run_best   <= score;
            run_idx    <= k;
          end else if (score < run_second) begin
            run_second <= score;
          end
          k <= k + IDX_W'(1);
        end
        DONE: begin
          if (start) overrun <= 1'b1;
          best_idx     <= run_idx;
          best_score   <= run_best;
          second_score <= run_second;
          is_unique    <= (run_best < run_second);
          gsum_best    <= snap_gs[gs_base(run_idx) +: GS_W];
          fsum_q       <= snap_fsum;
          done         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fgs_match_select.sv
// Scoreboard bench for fgs_match_select: a reference model predicts each
// scan result when the start edge is driven; results are checked on done.
module tb_fgs_match_select;
  import fgs_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic [FSUM_W-1:0]      fsum;
  logic [F2_W-1:0]        f2sum;
  logic [N_CAND*G2_W-1:0] g2sum;
  logic [N_CAND*GS_W-1:0] gsum;
  logic [N_CAND*FG_W-1:0] fg;
  logic                   valid;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       best_idx;
  logic [SCORE_W-1:0]     best_score;
  logic [SCORE_W-1:0]     second_score;
  logic                   is_unique;
  logic [GS_W-1:0]        gsum_best;
  logic [FSUM_W-1:0]      fsum_q;
  logic                   overrun;

  typedef struct {
    logic [IDX_W-1:0]   idx;
    logic [SCORE_W-1:0] best;
    logic [SCORE_W-1:0] second;
    logic               uniq;
    logic [GS_W-1:0]    gs;
    logic [FSUM_W-1:0]  fs;
    longint             start_cyc;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  int     done_count = 0;
  longint cyc = 0;

  longint          f2_v;
  longint          g2_v[N_CAND];
  longint          fg_v[N_CAND];
  longint          gs_v[N_CAND];
  logic [FSUM_W-1:0] fs_v;

  fgs_match_select dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fsum         (fsum),
    .f2sum        (f2sum),
    .g2sum        (g2sum),
    .gsum         (gsum),
    .fg           (fg),
    .valid        (valid),
    .busy         (busy),
    .done         (done),
    .best_idx     (best_idx),
    .best_score   (best_score),
    .second_score (second_score),
    .is_unique    (is_unique),
    .gsum_best    (gsum_best),
    .fsum_q       (fsum_q),
    .overrun      (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t buildExpected();
    exp_t   e;
    longint s[N_CAND];
    longint sec;
    int     bi;
    bit     have;
    for (int i = 0; i < N_CAND; i++) begin
      s[i] = f2_v + g2_v[i] - 2 * fg_v[i];
      if (s[i] < 0) s[i] = 0;
    end
    bi = 0;
    for (int i = 1; i < N_CAND; i++)
      if (s[i] < s[bi]) bi = i;
    have = 0;
    sec  = 0;
    for (int i = 0; i < N_CAND; i++)
      if (i != bi && (!have || s[i] < sec)) begin
        sec  = s[i];
        have = 1;
      end
    e.idx       = IDX_W'(bi);
    e.best      = SCORE_W'(s[bi]);
    e.second    = SCORE_W'(sec);
    e.uniq      = (s[bi] < sec);
    e.gs        = GS_W'(gs_v[bi]);
    e.fs        = fs_v;
    e.start_cyc = cyc + 1;
    return e;
  endfunction

  // kind: 0 single exact match, 1 all scores 7, 2 clamped tie, 3 random wide
  task automatic setVector(input int kind);
    f2_v = 0;
    for (int i = 0; i < N_CAND; i++) begin
      gs_v[i] = longint'(i) * 1000 + 7 + kind;
      case (kind)
        0: begin f2_v = 100; g2_v[i] = 100;  fg_v[i] = (i == 5) ? 100 : 90; end
        1: begin f2_v = 7;   g2_v[i] = longint'(i) * 1000; fg_v[i] = longint'(i) * 500; end
        2: begin
          f2_v = 50; g2_v[i] = 1000;
          fg_v[i] = (i == 3) ? 600 : (i == 9) ? 525 : 500;
        end
        default: begin
          f2_v    = longint'($urandom_range(0, 16383));
          g2_v[i] = longint'({$urandom, $urandom}) >> 8;
          fg_v[i] = longint'({$urandom, $urandom}) >> 9;
          gs_v[i] = longint'({$urandom, $urandom}) >> 20;
        end
      endcase
    end
    fs_v = FSUM_W'(11'h0A5 + kind * 97);
  endtask

  // Drive the buses, then a valid 1->0->1 edge; optionally predict the result
  task automatic applyStimulus(input bit expect_it);
    @(negedge clk);
    f2sum = F2_W'(f2_v);
    fsum  = fs_v;
    for (int i = 0; i < N_CAND; i++) begin
      g2sum[i*G2_W +: G2_W] = G2_W'(g2_v[i]);
      gsum[i*GS_W +: GS_W]  = GS_W'(gs_v[i]);
      fg[i*FG_W +: FG_W]    = FG_W'(fg_v[i]);
    end
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    if (expect_it) sb.push_back(buildExpected());
  endtask

  task automatic waitDone(input int target, input int budget);
    for (int i = 0; i < budget && done_count < target; i++) @(negedge clk);
    checkOutput("done_timeout", 64'(done_count >= target), 64'd1);
  endtask

  initial forever begin
    @(negedge clk);
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("latency",      64'(cyc - e.start_cyc), 64'd17);
        checkOutput("best_idx",     64'(best_idx),     64'(e.idx));
        checkOutput("best_score",   64'(best_score),   64'(e.best));
        checkOutput("second_score", 64'(second_score), 64'(e.second));
        checkOutput("unique",       64'(is_unique),    64'(e.uniq));
        checkOutput("gsum_best",    64'(gsum_best),    64'(e.gs));
        checkOutput("fsum_q",       64'(fsum_q),       64'(e.fs));
        checkOutput("busy_at_done", 64'(busy),         64'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b1;
    fsum  = '0;
    f2sum = '0;
    g2sum = '0;
    gsum  = '0;
    fg    = '0;
    #12;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("idle_no_done",     64'(done_count),   64'd0);
    checkOutput("idle_busy",        64'(busy),         64'd0);
    checkOutput("idle_best_idx",    64'(best_idx),     64'd0);
    checkOutput("idle_best_score",  64'(best_score),   64'd0);
    checkOutput("idle_second",      64'(second_score), 64'd0);
    checkOutput("idle_unique",      64'(is_unique),    64'd0);
    checkOutput("idle_gsum_best",   64'(gsum_best),    64'd0);
    checkOutput("idle_fsum_q",      64'(fsum_q),       64'd0);
    checkOutput("idle_overrun",     64'(overrun),      64'd0);

    setVector(0); applyStimulus(1);
    @(negedge clk);
    checkOutput("busy_scan", 64'(busy), 64'd1);
    waitDone(1, 40);
    setVector(1); applyStimulus(1); waitDone(2, 40);
    setVector(2); applyStimulus(1); waitDone(3, 40);
    for (int r = 0; r < 3; r++) begin
      setVector(3); applyStimulus(1); waitDone(4 + r, 40);
    end

    // Second start mid-scan with different buses: must be ignored
    setVector(3); applyStimulus(1);
    repeat (7) @(negedge clk);
    setVector(2); applyStimulus(0);
    waitDone(7, 40);
    repeat (30) @(negedge clk);
    checkOutput("overrun_single_done", 64'(done_count), 64'd7);
    checkOutput("overrun_set",         64'(overrun),    64'd1);
    setVector(0); applyStimulus(1);
    @(negedge clk);
    checkOutput("overrun_cleared", 64'(overrun), 64'd0);
    waitDone(8, 40);

    // Reset in the middle of a scan
    setVector(1); applyStimulus(0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",      64'(busy),         64'd0);
    checkOutput("midrst_best_idx",  64'(best_idx),     64'd0);
    checkOutput("midrst_second",    64'(second_score), 64'd0);
    checkOutput("midrst_unique",    64'(is_unique),    64'd0);
    checkOutput("midrst_gsum_best", 64'(gsum_best),    64'd0);
    checkOutput("midrst_fsum_q",    64'(fsum_q),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("midrst_no_done", 64'(done_count), 64'd8);
    setVector(1); applyStimulus(1); waitDone(9, 40);
    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
